// File: rtl/txbuf_ctrl_pkg.sv
// Shared types and constants for the transmit-buffer sequencing controller.
package txbuf_ctrl_pkg;

    localparam int TXBUF_BITS = 10000;
    localparam int NBYTES_DEF = TXBUF_BITS / 8;
    localparam int CNT_W      = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        FILL  = 3'd2,
        REQ   = 3'd3,
        ACK   = 3'd4,
        OUT   = 3'd5,
        DRAIN = 3'd6
    } state_t;

endpackage

// File: rtl/txbuf_wdog.sv
// Loadable down-counter for the per-byte handshake timeout.
// expired is high whenever the count sits at zero.
module txbuf_wdog #(
    parameter int W = 7
) (
    input  logic         clk_1200,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_1200 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/txbuf_ctrl.sv
// Transmit-buffer sequencer: arm, wait full, drain bytes over rfd/dav/ack into a valid/ready sink.
// Optional per-byte watchdog compiled in with `define TXBUF_CTRL_WDOG_EN.
module txbuf_ctrl
    import txbuf_ctrl_pkg::*;
#(
    parameter int NBYTES      = NBYTES_DEF,
    parameter int WDOG_CYCLES = 64
) (
    input  logic             clk_1200,
    input  logic             rst_n,
    input  logic             go,
    output logic             start,
    input  logic             tx_full,
    input  logic             tx_empty,
    output logic             rfd_tx,
    input  logic             dav_tx,
    input  logic [7:0]       tx_data,
    output logic             ack_tx,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] byte_cnt
);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt_inc, cnt_d;
    logic [7:0]       data_d;
    logic             last_byte, accept, go_ok, early_empty, wdog_fire;
    logic             start_d, busy_d, rfd_d, ack_d, valid_d, done_d, err_d;

    assign cnt_inc   = byte_cnt + 1'b1;
    assign last_byte = (cnt_inc == CNT_W'(NBYTES));
    assign accept    = (state == OUT) && m_ready;
    assign go_ok     = (state == IDLE) && go;
    // An empty seen in ACK lets the captured byte reach OUT; the abort happens once it is delivered.
    assign early_empty = tx_empty && ((state == REQ) || (accept && !last_byte));

`ifdef TXBUF_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic in_wait, wdog_expired;

    assign in_wait = (state == REQ) || (state == ACK);

    // Loaded with N-1 on REQ entry so the abort edge lands exactly N cycles later.
    txbuf_wdog #(.W(WDOG_W)) u_wdog (
        .clk_1200 (clk_1200),
        .rst_n    (rst_n),
        .clr      (state == IDLE),
        .load     ((next_state == REQ) && (state != REQ)),
        .load_val (WDOG_W'(WDOG_CYCLES - 1)),
        .en       (in_wait),
        .expired  (wdog_expired)
    );

    assign wdog_fire = in_wait && wdog_expired;
`else
    assign wdog_fire = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk_1200 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:  if (go) next_state = ARM;
            ARM:   next_state = FILL;
            FILL:  if (tx_full) next_state = REQ;
            REQ: begin
                if (wdog_fire || tx_empty) next_state = IDLE;
                else if (dav_tx)           next_state = ACK;
            end
            ACK: begin
                if (wdog_fire)                next_state = IDLE;
                else if (!dav_tx || tx_empty) next_state = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    if (last_byte)     next_state = DRAIN;
                    else if (tx_empty) next_state = IDLE;
                    else               next_state = REQ;
                end
            end
            DRAIN: if (tx_empty) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered, so they line up with it.
    always_comb begin
        start_d = (next_state == ARM);
        busy_d  = (next_state != IDLE);
        rfd_d   = (next_state == REQ);
        ack_d   = (next_state == ACK);
        valid_d = (next_state == OUT);
        done_d  = early_empty || wdog_fire || ((state == DRAIN) && tx_empty);
        err_d   = go_ok ? 1'b0 : (err || early_empty || wdog_fire);
        cnt_d   = byte_cnt;
        if (go_ok)
            cnt_d = '0;
        else if (accept && byte_cnt != CNT_W'(NBYTES))
            cnt_d = cnt_inc;
        data_d = m_data;
        if ((state == REQ) && dav_tx)
            data_d = tx_data;
    end

    always_ff @(posedge clk_1200 or negedge rst_n) begin
        if (!rst_n) begin
            start    <= 1'b0;
            busy     <= 1'b0;
            rfd_tx   <= 1'b0;
            ack_tx   <= 1'b0;
            m_valid  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            m_data   <= '0;
        end else begin
            start    <= start_d;
            busy     <= busy_d;
            rfd_tx   <= rfd_d;
            ack_tx   <= ack_d;
            m_valid  <= valid_d;
            done     <= done_d;
            err      <= err_d;
            byte_cnt <= cnt_d;
            m_data   <= data_d;
        end
    end

endmodule

// File: tb/tb_txbuf_ctrl.sv
// Self-checking bench for txbuf_ctrl: behavioural buffer and sink models driven on the falling edge.
// Watchdog expectations follow `define TXBUF_CTRL_WDOG_EN.
module tb_txbuf_ctrl;

    localparam int NB    = 1250;
    localparam int WDOG  = 64;
    localparam int SHIFT = 8;

    logic        clk_1200 = 1'b0;
    logic        rst_n, go, tx_full, tx_empty, dav_tx, m_ready;
    logic [7:0]  tx_data;
    logic        start, rfd_tx, ack_tx, m_valid, busy, done, err;
    logic [7:0]  m_data;
    logic [10:0] byte_cnt;
    logic [25:0] all_out;

    assign all_out = {start, rfd_tx, ack_tx, m_valid, busy, done, err, m_data, byte_cnt};

    always #5 clk_1200 = ~clk_1200;

    txbuf_ctrl #(.NBYTES(NB), .WDOG_CYCLES(WDOG)) dut (
        .clk_1200 (clk_1200),
        .rst_n    (rst_n),
        .go       (go),
        .start    (start),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .rfd_tx   (rfd_tx),
        .dav_tx   (dav_tx),
        .tx_data  (tx_data),
        .ack_tx   (ack_tx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .byte_cnt (byte_cnt)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] frame [NB];
    int         n_rx, n_start, done_seen, done_cyc, empty_cyc, rise_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_1200);
        cyc++;
    endtask

    // One frame: go, fill after fill_delay, then the buffer hands over n_fill bytes
    // (never byte index 'withhold'), raising tx_empty 'lag' cycles after the last one.
    task automatic run_frame(input int fill_delay, input int n_fill, input int withhold,
                             input int duty, input int lag, input int stop_at,
                             input int go_at, input int budget);
        int         bi, delay, elag;
        bit         raised, dropped, hold, pend, go_issued;
        logic [7:0] held;
        bi = 0; delay = 0; elag = 0; held = '0;
        raised = 0; dropped = 0; hold = 0; pend = 0; go_issued = 0;
        for (int i = 0; i < NB; i++) frame[i] = 8'($urandom);
        tx_full = 0; tx_empty = 0; dav_tx = 0; m_ready = 0;
        n_rx = 0; done_seen = 0; done_cyc = -1; empty_cyc = -1; rise_cyc = -1;

        go = 1; tick(); go = 0;
        check("go_start", start, 1);
        check("go_busy", busy, 1);
        check("go_err_clr", err, 0);
        check("go_cnt_clr", byte_cnt, 0);
        n_start = int'(start);
        tick();
        check("start_len", start, 0);
        repeat (fill_delay) tick();
        check("fill_wait", rfd_tx, 0);
        tx_full = 1;
        tick();
        check("fill_rfd", rfd_tx, 1);

        for (int c = 0; c < budget; c++) begin
            if (raised)  check("dav_to_ack", {ack_tx, rfd_tx}, 2'b10);
            if (dropped) check("ack_to_valid", {ack_tx, m_valid}, 2'b01);
            if (hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held);
            end
            raised = 0; dropped = 0; hold = 0;
            if (start) n_start++;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                break;
            end

            if (dav_tx && ack_tx) begin
                dav_tx = 0; bi++; delay = SHIFT; dropped = 1;
                if (bi == n_fill) begin pend = 1; elag = lag; end
            end else if (delay > 0) begin
                delay--;
            end
            if (pend) begin
                if (elag == 0) begin tx_empty = 1; empty_cyc = cyc; pend = 0; end
                else elag--;
            end
            if (rfd_tx && bi == withhold && rise_cyc < 0) rise_cyc = cyc;
            if (!dav_tx && !dropped && delay == 0 && rfd_tx && bi < n_fill && bi != withhold) begin
                dav_tx = 1; tx_data = frame[bi]; raised = 1;
            end

            if (stop_at >= 0 && m_valid && n_rx == stop_at) begin
                m_ready = 0;
                break;
            end
            m_ready = (int'($urandom_range(99, 0)) < duty);
            if (m_valid) begin
                if (m_ready) begin
                    check("cnt_track", byte_cnt, n_rx);
                    if (n_rx < NB) check("byte_order", m_data, frame[n_rx]);
                    else           check("overrun", n_rx, NB - 1);
                    n_rx++;
                end else begin
                    hold = 1; held = m_data;
                end
            end
            go = (go_at >= 0 && n_rx == go_at && !go_issued);
            if (go) go_issued = 1;
            tick();
        end
        go = 0;
        tx_full = 0;
    endtask

    initial begin
        rst_n = 0; go = 0; tx_full = 0; tx_empty = 0; dav_tx = 0; tx_data = '0; m_ready = 0;
        repeat (3) tick();
        check("reset_outputs", all_out, 0);
        rst_n = 1;
        tick();
        check("idle_outputs", all_out, 0);

        // Nominal frame, sink always ready.
        run_frame(300, NB, -1, 100, 5, -1, -1, 20000);
        check("nom_done", done_seen, 1);
        check("nom_done_at_empty", done_cyc - empty_cyc, 1);
        check("nom_rx", n_rx, NB);
        check("nom_cnt", byte_cnt, NB);
        check("nom_err", err, 0);
        check("nom_busy", busy, 0);
        check("nom_starts", n_start, 1);
        tick();
        check("nom_done_len", done, 0);
        check("nom_cnt_hold", byte_cnt, NB);

        // Sink backpressure at 30 % ready.
        run_frame(20, NB, -1, 30, 3, -1, -1, 40000);
        check("bp_done", done_seen, 1);
        check("bp_rx", n_rx, NB);
        check("bp_cnt", byte_cnt, NB);
        check("bp_err", err, 0);

        // Early empty after byte 100 with a go issued mid-frame.
        run_frame(15, 100, -1, 100, 0, -1, 50, 5000);
        check("ee_done", done_seen, 1);
        check("ee_err", err, 1);
        check("ee_cnt", byte_cnt, 100);
        check("ee_rx", n_rx, 100);
        check("ee_starts", n_start, 1);
        check("ee_busy", busy, 0);
        tick();
        check("ee_done_len", done, 0);
        check("ee_err_sticky", err, 1);

        // Buffer withholds dav on byte 7.
        run_frame(10, NB, 6, 100, 0, -1, -1, 600);
        check("wd_cnt", byte_cnt, 6);
        check("wd_rx", n_rx, 6);
`ifdef TXBUF_CTRL_WDOG_EN
        check("wd_done", done_seen, 1);
        check("wd_latency", done_cyc - rise_cyc, WDOG);
        check("wd_err", err, 1);
        check("wd_hs_low", {rfd_tx, ack_tx, busy}, 3'b000);
`else
        check("wd_no_done", done_seen, 0);
        check("wd_waiting", {rfd_tx, busy, err}, 3'b110);
        rst_n = 0; dav_tx = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
`endif

        // Reset while byte 500 sits in OUT.
        run_frame(10, NB, -1, 100, 5, 499, -1, 20000);
        check("mr_in_out", m_valid, 1);
        check("mr_cnt_before", byte_cnt, 499);
        rst_n = 0;
        #1;
        check("mr_async_clear", all_out, 0);
        dav_tx = 0; tx_full = 0; tx_empty = 0; m_ready = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        check("mr_after_release", all_out, 0);
        go = 1; tick(); go = 0;
        check("mr_idle_go", {start, busy}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
